tx_sq_arbiter: RTL
==================

# tx_sq_arbiter

Packet-granular round-robin arbiter that merges NUM_SQ per-queue-pair send-queue AXI-stream inputs into the single send-queue stream consumed by the TX datapath. A grant is held from the first beat of a work-queue message until its TLAST beat. Each completed message is reported with its queue ID and beat count so the header/metadata stage can build the packet headers. The block sits between the per-QP send queues and the TX segmenter/header logic.

## Interface
- NUM_SQ, 4: number of send-queue requesters; legal range 2..16.
- DATA_W, 64: stream data width in bits.
- MAX_BEATS, 256: beat-count saturation value.
- QID_W, $clog2(NUM_SQ): derived; not to be overridden.
- CNT_W, $clog2(MAX_BEATS+1): derived; not to be overridden.
- iClk  in  1  clock; all logic is on the rising edge.
- iRst  in  1  asynchronous, active-low reset.
- iSQ_TDATA  in  NUM_SQ*DATA_W  flattened per-queue data; queue k occupies bits [k*DATA_W +: DATA_W].
- iSQ_TVALID  in  NUM_SQ  per-queue valid.
- iSQ_TLAST  in  NUM_SQ  per-queue end of message.
- oSQ_TREADY  out  NUM_SQ  per-queue ready.
- oTX_TDATA  out  DATA_W  merged data.
- oTX_TVALID  out  1  merged valid.
- oTX_TLAST  out  1  merged last.
- iTX_TREADY  in  1  downstream ready.
- oTX_QID  out  QID_W  ID of the granted queue; valid whenever oTX_TVALID=1.
- oMSG_DONE  out  1  one-cycle pulse when a message's TLAST beat is accepted.
- oMSG_QID  out  QID_W  queue ID of the completed message; held until the next oMSG_DONE.
- oMSG_BEATS  out  CNT_W  beat count of the completed message, saturating at MAX_BEATS; held until the next oMSG_DONE.
- oBUSY  out  1  high while in XFER.

## Operation
- FSM has two states: IDLE and XFER.
- IDLE:
  - No oSQ_TREADY bit is asserted and oTX_TVALID=0.
  - If any iSQ_TVALID bit is set, the winner is the first valid queue found scanning upward from rr_ptr with wrap-around. The winner is registered into grant, the beat counter is cleared, and the FSM goes to XFER.
  - If no bit is set, the FSM stays in IDLE.
- XFER is a combinational pass-through of queue `grant`:
  - oTX_TDATA/oTX_TVALID/oTX_TLAST are driven from iSQ_*[grant].
  - oSQ_TREADY[grant]=iTX_TREADY; all other ready bits are 0.
  - oTX_QID=grant.
- Beat accepted = oTX_TVALID & iTX_TREADY. On every accepted beat, the counter increments and saturates at MAX_BEATS.
- Accepted TLAST beat:
  - oMSG_DONE=1 on the following cycle, with oMSG_QID=grant and oMSG_BEATS=final count including the last beat.
  - rr_ptr = (grant+1) mod NUM_SQ, with wrap from NUM_SQ-1 to 0.
  - FSM returns to IDLE.
- A grant is never preempted mid-message. Requests from other queues wait.
- If iSQ_TVALID[grant] drops mid-message, the block stays in XFER with oTX_TVALID=0. The stall has no timeout.
- A 1-beat message (TLAST on the first beat) gives oMSG_BEATS=1.
- Reaching saturation does not force TLAST. The count sticks at MAX_BEATS and data continues to pass.

## Timing
- Reset values: state=IDLE, rr_ptr=0, grant=0, counter=0, and all outputs 0 (oSQ_TREADY=0, oTX_TVALID=0, oTX_TLAST=0, oTX_TDATA=0, oTX_QID=0, oMSG_*=0, oBUSY=0).
- Arbitration latency is one cycle: a request seen in IDLE at cycle t gives first-beat visibility at t+1.
- One IDLE bubble cycle follows every message. Back-to-back messages therefore run at one message per (beats+1) cycles.
- Data path latency in XFER is 0 cycles (combinational). oMSG_* are registered, one cycle after the TLAST acceptance.
- Reset asserted mid-message: everything returns to the reset values immediately, with no flush of the partial message. The upstream queue must re-present the message from its start.
- Downstream must not rely on oTX_TVALID staying high across a stalled upstream. Data stability under backpressure holds only because the upstream is an AXI-stream source.

## Configuration
- TX_SQ_ARB_PRIO_EN defined:
  - Queue 0 is strict-priority. In IDLE, iSQ_TVALID[0]=1 always wins.
  - Otherwise round-robin runs over queues 1..NUM_SQ-1.
  - rr_ptr updates only after non-zero grants, and wraps from NUM_SQ-1 to 1.
  - Queue 0 completion leaves rr_ptr unchanged.
- TX_SQ_ARB_PRIO_EN undefined: plain round-robin over all NUM_SQ queues as described above.

## Test plan
- Reset, then queue 2 sends 3 beats with TLAST on beat 3 and iTX_TREADY=1. Required:
  - oTX_QID=2 for 3 beats.
  - oMSG_DONE pulses once with oMSG_QID=2 and oMSG_BEATS=3.
  - rr_ptr=3.
- All 4 queues hold 1-beat messages continuously from reset. Required:
  - Grant order 0,1,2,3,0.
  - Each message is followed by exactly one idle cycle.
- Queue 1 sends 4 beats with iTX_TREADY toggling 1,0,1,0… Required:
  - Only oSQ_TREADY[1] ever mirrors iTX_TREADY.
  - oMSG_BEATS=4.
  - Queue 3 valid throughout is not granted until queue 1's TLAST.
- MAX_BEATS=8; queue 0 sends 12 beats. Required:
  - oMSG_BEATS=8.
  - All 12 beats pass with oTX_TLAST only on beat 12.
- iRst asserted after beat 2 of a 5-beat queue-1 message. Required:
  - All outputs are 0 during reset.
  - After release, arbitration restarts with rr_ptr=0 and no oMSG_DONE is issued for the aborted message.
- With TX_SQ_ARB_PRIO_EN: queues 0 and 2 both continuously valid. Required:
  - Queue 0 is granted every time.
  - When queue 0 idles, queues 1–3 rotate 1,2,3,1.

Source files
------------

// File: rtl/tx_sq_arbiter.sv
// ---------------------------------------------------------------------------
// tx_sq_arbiter
//
// Packet-granular round-robin arbiter. It merges NUM_SQ send-queue
// AXI-stream inputs into the single stream that feeds the TX datapath. Once
// a queue is granted, it keeps the grant from the first beat of a message
// through its TLAST beat. Every completed message is reported with its queue
// ID and beat count.
//
// Optional feature: define TX_SQ_ARB_PRIO_EN to give queue 0 strict priority.
// Round-robin then runs only over queues 1..NUM_SQ-1.
//
// Parameters
//   NUM_SQ     number of send-queue requesters (2..16)
//   DATA_W     stream data width
//   MAX_BEATS  beat-count saturation value
//   QID_W      derived queue-ID width
//   CNT_W      derived beat-count width
//
// Ports
//   iClk        clock, rising edge
//   iRst        asynchronous active-low reset
//   iSQ_TDATA   flattened per-queue data, queue k at [k*DATA_W +: DATA_W]
//   iSQ_TVALID  per-queue valid
//   iSQ_TLAST   per-queue end of message
//   oSQ_TREADY  per-queue ready (only the granted queue, only in XFER)
//   oTX_TDATA   merged data
//   oTX_TVALID  merged valid
//   oTX_TLAST   merged last
//   iTX_TREADY  downstream ready
//   oTX_QID     granted queue ID (meaningful while oTX_TVALID=1)
//   oMSG_DONE   one-cycle pulse after a TLAST beat is accepted
//   oMSG_QID    queue ID of the last completed message (held)
//   oMSG_BEATS  saturated beat count of the last completed message (held)
//   oBUSY       high while a message is being transferred
// ---------------------------------------------------------------------------
module tx_sq_arbiter #(
  parameter  int NUM_SQ    = 4,
  parameter  int DATA_W    = 64,
  parameter  int MAX_BEATS = 256,
  localparam int QID_W     = $clog2(NUM_SQ),
  localparam int CNT_W     = $clog2(MAX_BEATS + 1)
) (
  input  logic                     iClk,
  input  logic                     iRst,
  input  logic [NUM_SQ*DATA_W-1:0] iSQ_TDATA,
  input  logic [NUM_SQ-1:0]        iSQ_TVALID,
  input  logic [NUM_SQ-1:0]        iSQ_TLAST,
  output logic [NUM_SQ-1:0]        oSQ_TREADY,
  output logic [DATA_W-1:0]        oTX_TDATA,
  output logic                     oTX_TVALID,
  output logic                     oTX_TLAST,
  input  logic                     iTX_TREADY,
  output logic [QID_W-1:0]         oTX_QID,
  output logic                     oMSG_DONE,
  output logic [QID_W-1:0]         oMSG_QID,
  output logic [CNT_W-1:0]         oMSG_BEATS,
  output logic                     oBUSY
);

  localparam int unsigned NQ = NUM_SQ;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [QID_W-1:0] grant, grant_nxt;
  logic [QID_W-1:0] rr_ptr, rr_ptr_nxt;
  logic [QID_W-1:0] winner;
  logic             found;
  logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt, cnt_inc;
  logic             msg_done;
  logic [QID_W-1:0] msg_qid;
  logic [CNT_W-1:0] msg_beats;
  logic             accept;
  logic             last_accept;
  logic [QID_W-1:0] grant_succ;

  // Winner selection: the first valid queue at or above rr_ptr, with wrap.
  always_comb begin
    winner = '0;
    found  = 1'b0;
`ifdef TX_SQ_ARB_PRIO_EN
    if (iSQ_TVALID[0]) begin
      found = 1'b1;
    end else begin
      // The ring excludes queue 0. A pointer of 0 (reset) starts at queue 1.
      for (int unsigned i = 0; i < NQ - 1; i++) begin
        int unsigned base;
        int unsigned idx;
        logic [QID_W-1:0] cand;
        base = 32'(rr_ptr);
        if (base == 0) base = 1;
        idx  = 1 + ((base - 1 + i) % (NQ - 1));
        cand = QID_W'(idx);
        if (!found && iSQ_TVALID[cand]) begin
          winner = cand;
          found  = 1'b1;
        end
      end
    end
`else
    for (int unsigned i = 0; i < NQ; i++) begin
      int unsigned idx;
      logic [QID_W-1:0] cand;
      idx  = (32'(rr_ptr) + i) % NQ;
      cand = QID_W'(idx);
      if (!found && iSQ_TVALID[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
`endif
  end

  // Pointer value to use after the current grant completes.
  always_comb begin
`ifdef TX_SQ_ARB_PRIO_EN
    if (grant == '0) begin
      grant_succ = rr_ptr;
    end else if (grant == QID_W'(NUM_SQ - 1)) begin
      grant_succ = QID_W'(1);
    end else begin
      grant_succ = grant + 1'b1;
    end
`else
    if (grant == QID_W'(NUM_SQ - 1)) begin
      grant_succ = '0;
    end else begin
      grant_succ = grant + 1'b1;
    end
`endif
  end

  // Output pass-through: it is combinational from the granted queue while in
  // XFER, and all zero in IDLE.
  always_comb begin
    oSQ_TREADY = '0;
    oTX_TDATA  = '0;
    oTX_TVALID = 1'b0;
    oTX_TLAST  = 1'b0;
    oTX_QID    = '0;
    if (state == XFER) begin
      oTX_TDATA         = iSQ_TDATA[grant*DATA_W +: DATA_W];
      oTX_TVALID        = iSQ_TVALID[grant];
      oTX_TLAST         = iSQ_TLAST[grant];
      oTX_QID           = grant;
      oSQ_TREADY[grant] = iTX_TREADY;
    end
  end

  assign accept      = oTX_TVALID & iTX_TREADY;
  assign last_accept = accept & oTX_TLAST;

  // The count sticks at MAX_BEATS and never forces an end of message.
  assign cnt_inc = (beat_cnt == CNT_W'(MAX_BEATS)) ? beat_cnt : beat_cnt + 1'b1;

  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant;
    rr_ptr_nxt   = rr_ptr;
    beat_cnt_nxt = beat_cnt;
    case (state)
      IDLE: begin
        if (found) begin
          grant_nxt    = winner;
          beat_cnt_nxt = '0;
          state_nxt    = XFER;
        end
      end
      XFER: begin
        if (accept) beat_cnt_nxt = cnt_inc;
        if (last_accept) begin
          rr_ptr_nxt = grant_succ;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state     <= IDLE;
      grant     <= '0;
      rr_ptr    <= '0;
      beat_cnt  <= '0;
      msg_done  <= 1'b0;
      msg_qid   <= '0;
      msg_beats <= '0;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      rr_ptr   <= rr_ptr_nxt;
      beat_cnt <= beat_cnt_nxt;
      msg_done <= last_accept;
      if (last_accept) begin
        msg_qid   <= grant;
        msg_beats <= cnt_inc;
      end
    end
  end

  assign oMSG_DONE  = msg_done;
  assign oMSG_QID   = msg_qid;
  assign oMSG_BEATS = msg_beats;
  assign oBUSY      = (state == XFER);

endmodule
